// File: rtl/soft_ccc_pkg.sv
// Shared definitions for the soft_ccc_div clock-conditioning slice.
// The ratio is encoded as DIV+1. GL is high while the count is below the half point.
package soft_ccc_pkg;

    localparam int unsigned DIVW_DEF        = 5;
    localparam int unsigned DEFAULT_DIV_DEF = 4;

    // Divide ratio produced by a DIV field value.
    function automatic int unsigned div_to_ratio(input int unsigned div);
        return div + 1;
    endfunction

    // Number of GL-high cycles per period. For an odd ratio the extra cycle goes to the high phase.
    function automatic int unsigned half_point(input int unsigned div);
        return (div + 2) >> 1;
    endfunction

    // Width of the channel-select field. It is never narrower than one bit.
    function automatic int unsigned ch_idx_w(input int unsigned nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/soft_ccc_chan.sv
// One divider channel: a terminal-count counter with a one-deep pending-ratio slot.
// A pending ratio takes effect only at terminal count, so no period is ever truncated.
module soft_ccc_chan
    import soft_ccc_pkg::*;
#(
    parameter int unsigned DIVW        = DIVW_DEF,
    parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_wr,
    input  logic [DIVW-1:0] cfg_div,
    output logic            gl_en,
    output logic            gl,
    output logic            pend
);

    logic [DIVW-1:0] cnt;
    logic [DIVW-1:0] div;
    logic [DIVW-1:0] pend_div;
    logic [DIVW:0]   half;
    logic            tc;

    assign tc = (cnt == div);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            div      <= DIVW'(DEFAULT_DIV);
            pend_div <= DIVW'(DEFAULT_DIV);
            pend     <= 1'b0;
        end else begin
            if (tc) begin
                cnt <= '0;
                if (pend) begin
                    div  <= pend_div;
                    pend <= 1'b0;
                end
            end else begin
                cnt <= cnt + DIVW'(1);
            end
            // A write on the terminal-count edge only arms the slot. The swap waits for the next wrap.
            if (cfg_wr) begin
                pend_div <= cfg_div;
                pend     <= 1'b1;
            end
        end
    end

    assign half  = (DIVW+1)'(half_point(32'(div)));
    assign gl_en = tc;
    assign gl    = ({1'b0, cnt} < half);

endmodule

// File: rtl/soft_ccc_div.sv
// NCH-channel run-time reprogrammable clock divider with a valid/ready config port and LOCK.
// SOFT_CCC_LOCK_EN selects the LOCK_CYCLES stability counter. Otherwise LOCK only tracks pending requests.
module soft_ccc_div
    import soft_ccc_pkg::*;
#(
    parameter int unsigned NCH         = 3,
    parameter int unsigned DIVW        = DIVW_DEF,
    parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF,
    parameter int unsigned LOCK_CYCLES = 64
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      CFG_VALID,
    output logic                      CFG_READY,
    input  logic [ch_idx_w(NCH)-1:0]  CFG_CH,
    input  logic [DIVW-1:0]           CFG_DIV,
    output logic [NCH-1:0]            GL_EN,
    output logic [NCH-1:0]            GL,
    output logic                      LOCK
);

    logic           accept;
    logic [NCH-1:0] wr;
    logic [NCH-1:0] pend;
    logic           any_pend;

    assign accept   = CFG_VALID && CFG_READY;
    assign any_pend = |pend;

    // An out-of-range CFG_CH matches no channel. The request is therefore consumed without effect.
    always_comb begin
        wr = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            wr[i] = accept && (32'(CFG_CH) == i);
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        soft_ccc_chan #(
            .DIVW        (DIVW),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk     (CLK),
            .rst     (RESET),
            .cfg_wr  (wr[i]),
            .cfg_div (CFG_DIV),
            .gl_en   (GL_EN[i]),
            .gl      (GL[i]),
            .pend    (pend[i])
        );
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            CFG_READY <= 1'b1;
        end else begin
            CFG_READY <= ~any_pend;
        end
    end

`ifdef SOFT_CCC_LOCK_EN
    localparam int unsigned LCW = $clog2(LOCK_CYCLES + 1);

    logic [LCW-1:0] lock_cnt;
    logic [LCW-1:0] lock_cnt_nxt;

    always_comb begin
        lock_cnt_nxt = lock_cnt;
        if ((|wr) || any_pend) begin
            lock_cnt_nxt = '0;
        end else if (lock_cnt != LCW'(LOCK_CYCLES)) begin
            lock_cnt_nxt = lock_cnt + LCW'(1);
        end
    end

    // LOCK is registered from the next count. It therefore rises on the same edge the count saturates.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            lock_cnt <= '0;
            LOCK     <= 1'b0;
        end else begin
            lock_cnt <= lock_cnt_nxt;
            LOCK     <= (lock_cnt_nxt == LCW'(LOCK_CYCLES));
        end
    end
`else
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            LOCK <= 1'b0;
        end else begin
            LOCK <= ~any_pend;
        end
    end
`endif

endmodule

// File: tb/tb_soft_ccc_div.sv
// Directed bench for soft_ccc_div (NCH=3, DIVW=5, DEFAULT_DIV=4, LOCK_CYCLES=64).
// n is the number of rising edges since reset release. Outputs are sampled 1 time unit after each edge.
module tb_soft_ccc_div;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       CFG_VALID = 1'b0;
    logic       CFG_READY;
    logic [1:0] CFG_CH = '0;
    logic [4:0] CFG_DIV = '0;
    logic [2:0] GL_EN;
    logic [2:0] GL;
    logic       LOCK;

    int checks = 0;
    int failures = 0;
    int unsigned n = 0;
    int unsigned per [3];
    int unsigned base [3];

    // Per-phase waveforms. Bit k holds the value at phase k.
    logic [4:0] gl5_tab = 5'b00111;
    logic [4:0] en5_tab = 5'b10000;
    logic [1:0] gl2_tab = 2'b01;
    logic [1:0] en2_tab = 2'b10;

    soft_ccc_div #(
        .NCH         (3),
        .DIVW        (5),
        .DEFAULT_DIV (4),
        .LOCK_CYCLES (64)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .CFG_VALID (CFG_VALID),
        .CFG_READY (CFG_READY),
        .CFG_CH    (CFG_CH),
        .CFG_DIV   (CFG_DIV),
        .GL_EN     (GL_EN),
        .GL        (GL),
        .LOCK      (LOCK)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s n=%0d got=%0h exp=%0h", tag, n, got, exp);
        end
    endtask

    task automatic check_chans();
        logic [2:0] e_gl;
        logic [2:0] e_en;
        int unsigned ph;
        for (int c = 0; c < 3; c++) begin
            ph = (n - base[c]) % per[c];
            case (per[c])
                5: begin e_gl[c] = gl5_tab[ph]; e_en[c] = en5_tab[ph]; end
                2: begin e_gl[c] = gl2_tab[ph]; e_en[c] = en2_tab[ph]; end
                default: begin e_gl[c] = 1'b1; e_en[c] = 1'b1; end
            endcase
        end
        check_eq("gl", 32'(GL), 32'(e_gl));
        check_eq("gl_en", 32'(GL_EN), 32'(e_en));
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        n++;
        check_chans();
    endtask

    task automatic run_to(input int unsigned target);
        while (n < target) step();
    endtask

    task automatic model_reset();
        n = 0;
        for (int c = 0; c < 3; c++) begin
            per[c] = 5;
            base[c] = 0;
        end
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        check_eq("rst_gl", 32'(GL), 32'h7);
        check_eq("rst_gl_en", 32'(GL_EN), 32'h0);
        check_eq("rst_ready", 32'(CFG_READY), 32'h1);
        check_eq("rst_lock", 32'(LOCK), 32'h0);
        RESET = 1'b0;
        check_eq("rel_lock", 32'(LOCK), 32'h0);

        // Defaults: /5 on every channel, first GL_EN at n=4.
        run_to(63);
`ifdef SOFT_CCC_LOCK_EN
        check_eq("lock_63", 32'(LOCK), 32'h0);
`else
        check_eq("lock_63", 32'(LOCK), 32'h1);
`endif
        run_to(64);
        check_eq("lock_64", 32'(LOCK), 32'h1);
        check_eq("ready_64", 32'(CFG_READY), 32'h1);

        // CH1 <- DIV=1 accepted mid-period at edge 67. The switch occurs at edge 70.
        run_to(66);
        CFG_VALID = 1'b1; CFG_CH = 2'd1; CFG_DIV = 5'd1;
        step();
        CFG_VALID = 1'b0;
        run_to(68);
        check_eq("ch1_ready_68", 32'(CFG_READY), 32'h0);
        check_eq("ch1_lock_68", 32'(LOCK), 32'h0);
        run_to(69);
        per[1] = 2; base[1] = 70;
        run_to(70);
        check_eq("ch1_ready_70", 32'(CFG_READY), 32'h0);
        check_eq("ch1_lock_70", 32'(LOCK), 32'h0);
        run_to(71);
        check_eq("ch1_ready_71", 32'(CFG_READY), 32'h1);
`ifdef SOFT_CCC_LOCK_EN
        check_eq("ch1_lock_71", 32'(LOCK), 32'h0);
        run_to(133);
        check_eq("ch1_lock_133", 32'(LOCK), 32'h0);
        run_to(134);
        check_eq("ch1_lock_134", 32'(LOCK), 32'h1);
`else
        check_eq("ch1_lock_71", 32'(LOCK), 32'h1);
`endif

        // CH0 <- DIV=0 accepted on its terminal-count edge 140. One more /5 period follows, then the switch at 145.
        run_to(139);
        CFG_VALID = 1'b1; CFG_CH = 2'd0; CFG_DIV = 5'd0;
        step();
        CFG_VALID = 1'b0;
        run_to(141);
        check_eq("ch0_ready_141", 32'(CFG_READY), 32'h0);
        check_eq("ch0_lock_141", 32'(LOCK), 32'h0);
        run_to(144);
        per[0] = 1; base[0] = 145;
        run_to(145);
        check_eq("ch0_ready_145", 32'(CFG_READY), 32'h0);
        run_to(146);
        check_eq("ch0_ready_146", 32'(CFG_READY), 32'h1);
`ifdef SOFT_CCC_LOCK_EN
        run_to(208);
        check_eq("ch0_lock_208", 32'(LOCK), 32'h0);
        run_to(209);
        check_eq("ch0_lock_209", 32'(LOCK), 32'h1);
`else
        check_eq("ch0_lock_146", 32'(LOCK), 32'h1);
`endif

        // An out-of-range channel is accepted and has no effect.
        run_to(210);
        CFG_VALID = 1'b1; CFG_CH = 2'd3; CFG_DIV = 5'd7;
        step();
        CFG_VALID = 1'b0;
        check_eq("ch3_ready_211", 32'(CFG_READY), 32'h1);
        check_eq("ch3_lock_211", 32'(LOCK), 32'h1);
        run_to(212);
        check_eq("ch3_ready_212", 32'(CFG_READY), 32'h1);
        check_eq("ch3_lock_212", 32'(LOCK), 32'h1);
        run_to(215);

        // CH2 <- DIV=31 is left pending, then an asynchronous reset discards it.
        CFG_VALID = 1'b1; CFG_CH = 2'd2; CFG_DIV = 5'd31;
        step();
        CFG_VALID = 1'b0;
        step();
        check_eq("ch2_ready_217", 32'(CFG_READY), 32'h0);
        RESET = 1'b1;
        #1;
        check_eq("arst_gl", 32'(GL), 32'h7);
        check_eq("arst_gl_en", 32'(GL_EN), 32'h0);
        check_eq("arst_ready", 32'(CFG_READY), 32'h1);
        check_eq("arst_lock", 32'(LOCK), 32'h0);
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        model_reset();
        run_to(12);
        check_eq("post_ready", 32'(CFG_READY), 32'h1);
`ifdef SOFT_CCC_LOCK_EN
        check_eq("post_lock", 32'(LOCK), 32'h0);
`else
        check_eq("post_lock", 32'(LOCK), 32'h1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/soft_ccc_div.md
# soft_ccc_div

Parametrised fabric clock-conditioning block: generates NCH independent divided clock-enable/square-wave channels from one fabric clock, each ratio reprogrammable at run time, with a glitch-free switch at terminal count. Sits after the MSS CCC fabric clock output (FAB_CLK) and replaces fixed output dividers. Provides a LOCK indication qualifying all channel outputs after reset or reconfiguration.

## Interface
- NCH, 3, number of output channels (1..8)
- DIVW, 5, divider field width; ratio = DIV+1
- DEFAULT_DIV, 4, per-channel DIV after reset (/5)
- LOCK_CYCLES, 64, stable cycles before LOCK asserts (>=1)

- CLK  in  1  fabric clock; all logic on rising edge
- RESET  in  1  asynchronous, active-high reset
- CFG_VALID  in  1  reconfiguration request
- CFG_READY  out  1  block can accept a request
- CFG_CH  in  $clog2(NCH) (min 1)  target channel
- CFG_DIV  in  DIVW  new DIV value
- GL_EN  out  NCH  per-channel one-cycle enable, once per divided period
- GL  out  NCH  per-channel divided square wave
- LOCK  out  1  all channels running at their programmed ratio for LOCK_CYCLES

## Operation
- Per channel: cnt (DIVW bits), div, pend_div, pend flag. cnt counts 0..div, wraps to 0.
- GL_EN[i] = (cnt==div); GL[i] = (cnt < half), half = (div+2)>>1, computed DIVW+1 bits wide. Decoded from registers only; no path from CFG_* to GL/GL_EN.
- div=0: GL_EN constant 1, GL constant 1. div=1: GL 50 % at CLK/2. div=4: GL high 3, low 2.
- Handshake: request accepted on rising edge with CFG_VALID && CFG_READY. Accepted value loads pend_div, sets pend for CFG_CH. CFG_CH >= NCH: accepted, discarded, LOCK unaffected.
- Switch: on edge where cnt==div and pend already set, div<=pend_div, cnt<=0, pend cleared. Switch happens only at terminal count; no truncated period.
- Accept on same edge as target's terminal count: not applied then; applied at next terminal count (one more old-ratio period).
- CFG_READY = registered NOR of all pend flags; low from edge after acceptance until edge after switch.
- LOCK: counter lock_cnt saturates at LOCK_CYCLES. Cleared (with LOCK) on valid-channel acceptance; held at 0 while any pend set; else increments. LOCK = (lock_cnt==LOCK_CYCLES), registered.

## Timing
- Reset values: cnt=0, div=DEFAULT_DIV, pend=0, CFG_READY=1, LOCK=0, lock_cnt=0; hence GL=1, GL_EN=0 (for DEFAULT_DIV>0).
- First GL_EN after reset release: cycle DEFAULT_DIV (edge count from release, 0-based).
- LOCK rises after LOCK_CYCLES edges post-reset; after reconfig, LOCK_CYCLES edges after the switch edge.
- RESET mid-switch: pending discarded, channel returns to DEFAULT_DIV immediately (asynchronous).
- Latency accept→switch: remaining old-period cycles, max div_old+1.

## Configuration
- SOFT_CCC_LOCK_EN defined: lock_cnt and LOCK behaviour as above.
- Not defined: no lock counter; LOCK = registered NOR of pend flags, reset 0, 1 from first edge after reset release.

## Structure
- Package soft_ccc_pkg: ratio encoding (ratio = DIV+1), half-point function, DEFAULT_DIV/DIVW defaults, channel-index width function.
- Sub-module soft_ccc_chan: one channel (cnt, div, pending slot, GL/GL_EN decode, pend output); top instantiates NCH copies plus handshake and lock logic.

## Test plan
- Reset release, defaults -> GL_EN[i] pulses every 5 cycles (first at cycle 4), GL high 3/low 2, LOCK at edge 64, CFG_READY=1.
- Write CH1 DIV=1 mid-period -> CFG_READY low, CH1 completes /5 period, then /2 50 % GL; CH0/CH2 unchanged; LOCK low, re-high 64 edges after switch.
- Write CH0 DIV=0 on CH0 terminal-count edge -> one more /5 period, then GL_EN[0] and GL[0] constant 1.
- Write CFG_CH=3 (NCH=3) -> accepted, no channel change, LOCK stays 1, CFG_READY stays 1.
- Assert RESET with CH2 pending DIV=31 -> immediate return to reset values; after release CH2 runs /5, no switch to /32.
- Build without SOFT_CCC_LOCK_EN -> LOCK high at edge 1 after release, low only while a request is pending.
